// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - MMIO page offsets and STATUS bit layout for dmem_mmio
package mmio_pkg;

    // Register offsets from MMIO_BASE
    localparam logic [7:0] LED_OFS    = 8'h00;
    localparam logic [7:0] CNTLO_OFS  = 8'h01;
    localparam logic [7:0] CNTHI_OFS  = 8'h02;
    localparam logic [7:0] TXDATA_OFS = 8'h04;
    localparam logic [7:0] STATUS_OFS = 8'h05;

    // STATUS register bit positions; count occupies three bits from ST_CNT_LSB
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - transmit byte FIFO with head-of-queue output
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted only when it is paired with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];

    // Storage is not reset; only the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data-memory responder: byte RAM plus LED, cycle counter and TX FIFO page
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] MMIO_BASE  = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       memwrite,
    input  logic [7:0] aluout,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic [7:0] led,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    ram [0:MMIO_BASE-1];
    logic          is_mmio;
    logic [7:0]    ofs;
    logic          sel_led;
    logic          sel_cntlo;
    logic          sel_cnthi;
    logic          sel_tx;
    logic          sel_status;
    logic [15:0]   counter;
    logic [7:0]    shadow;
    logic          ovf;
    logic          tx_push;
    logic          tx_pop;
    logic          ovf_set;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    status;
    logic [7:0]    mmio_rd;

    assign is_mmio    = (aluout >= MMIO_BASE);
    assign ofs        = aluout - MMIO_BASE;
    assign sel_led    = is_mmio && (ofs == LED_OFS);
    assign sel_cntlo  = is_mmio && (ofs == CNTLO_OFS);
    assign sel_cnthi  = is_mmio && (ofs == CNTHI_OFS);
    assign sel_tx     = is_mmio && (ofs == TXDATA_OFS);
    assign sel_status = is_mmio && (ofs == STATUS_OFS);

    assign tx_valid = !fifo_empty;
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_push  = memwrite && sel_tx;
    // A push into a full FIFO is only lost when no pop makes room that cycle
    assign ovf_set  = tx_push && fifo_full && !tx_pop;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (writedata),
        .head  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Byte RAM store; contents survive reset
    always_ff @(posedge clk) begin
        if (memwrite && !is_mmio) begin
            ram[aluout] <= writedata;
        end
    end

    // LED register, free-running counter with high-byte snapshot, sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led     <= '0;
            counter <= '0;
            shadow  <= '0;
            ovf     <= 1'b0;
        end else begin
            if (memwrite && sel_led) begin
                led <= writedata;
            end
            if (memwrite && sel_cntlo) begin
                counter <= '0;
            end else begin
                counter <= counter + 16'd1;
            end
            // Capturing the high byte on the low-byte read keeps a two-load read coherent
            if (!memwrite && sel_cntlo) begin
                shadow <= counter[15:8];
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (memwrite && sel_status && writedata[ST_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

    // STATUS layout and MMIO read mux
    always_comb begin
        status                    = '0;
        status[ST_EMPTY]          = fifo_empty;
        status[ST_FULL]           = fifo_full;
        status[ST_OVF]            = ovf;
        status[ST_CNT_LSB +: 3]   = 3'(fifo_count);
        mmio_rd = '0;
        if (sel_led) begin
            mmio_rd = led;
        end else if (sel_cntlo) begin
            mmio_rd = counter[7:0];
        end else if (sel_cnthi) begin
            mmio_rd = shadow;
        end else if (sel_status) begin
            mmio_rd = status;
        end
        readdata = is_mmio ? mmio_rd : ram[aluout];
    end

endmodule
